bcd_to_bin: RTL and testbench



---
 rtl/slot_pkg.sv | 14 +
 rtl/bcd_mac_step.sv | 24 ++
 rtl/bcd_to_bin.sv | 118 +++++++++++
 tb/tb_bcd_to_bin.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared score widths, BCD limit and converter state encoding
package slot_pkg;

    localparam int SCORE_DIGITS = 4;
    localparam int SCORE_W      = 14;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

endpackage

// File: rtl/bcd_mac_step.sv
// rtl/bcd_mac_step.sv - one decimal multiply-accumulate step: acc*10 + clamp(digit)
module bcd_mac_step
    import slot_pkg::*;
#(
    parameter int BIN_W = SCORE_W
) (
    input  logic [BIN_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] acc_out,
    output logic             bad_digit
);

    logic [BIN_W+3:0] acc_wide;
    logic [3:0]       digit_clamped;

    // Shift-add times ten at four extra bits; the width bound on BIN_W and the clamp keep the truncation lossless.
    always_comb begin
        bad_digit     = (digit > BCD_MAX);
        digit_clamped = bad_digit ? BCD_MAX : digit;
        acc_wide      = {4'b0000, acc_in};
        acc_out       = BIN_W'((acc_wide << 3) + (acc_wide << 1) + (BIN_W + 4)'(digit_clamped));
    end

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential packed-BCD to binary converter, MSD first, valid/ready on both sides
module bcd_to_bin
    import slot_pkg::*;
#(
    parameter int NUM_DIGITS = SCORE_DIGITS,
    parameter int BIN_W      = SCORE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    err
);

    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

    conv_state_e             state_q,     state_d;
    logic [BIN_W-1:0]        acc_q,       acc_d;
    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q,    digits_d;
    logic                    err_q,       err_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q,  in_ready_d;
    logic [BIN_W-1:0]        bin_out_q,   bin_out_d;

    logic [BIN_W-1:0] mac_acc;
    logic             mac_bad;

    bcd_mac_step #(
        .BIN_W (BIN_W)
    ) u_mac_step (
        .acc_in    (acc_q),
        .digit     (digits_q[4*NUM_DIGITS-1 -: 4]),
        .acc_out   (mac_acc),
        .bad_digit (mac_bad)
    );

    // Next-state logic: capture in IDLE, one digit per cycle in CONV, hold result in DONE until drained.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        digits_d    = digits_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        bin_out_d   = bin_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    digits_d   = bcd_in;
                    acc_d      = '0;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                acc_d    = mac_acc;
                err_d    = err_q | mac_bad;
                digits_d = digits_q << 4;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    bin_out_d   = mac_acc;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            digits_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            bin_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            bin_out_q   <= bin_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - randomized self-checking bench for bcd_to_bin against a decimal reference model
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] bin_out;
    logic        err;

    int checks;
    int errors;

    bcd_to_bin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: weighted decimal sum of clamped digits, error if any digit exceeds nine.
    function automatic int ref_value(input logic [15:0] bcd);
        int total;
        int weight;
        int d;
        total = 0;
        weight = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'((bcd >> (4 * i)) & 16'hF);
            total += ((d > 9) ? 9 : d) * weight;
            weight *= 10;
        end
        return total;
    endfunction

    function automatic bit ref_err(input logic [15:0] bcd);
        bit e;
        e = 1'b0;
        for (int i = 0; i < 4; i++)
            if (((bcd >> (4 * i)) & 16'hF) > 16'd9) e = 1'b1;
        return e;
    endfunction

    // Digit splitter model: binary value to packed BCD.
    function automatic logic [15:0] split_digits(input int v);
        logic [15:0] r;
        r = 16'h0;
        for (int i = 0; i < 4; i++) begin
            r |= 16'((v % 10) << (4 * i));
            v /= 10;
        end
        return r;
    endfunction

    // Presents v from a negedge, returns at the negedge one cycle after the accept edge; ok=0 on timeout.
    task automatic accept(input logic [15:0] v, output bit ok);
        int n;
        n = 0;
        bcd_in = v;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 100);
        @(negedge clk);
        in_valid = 1'b0;
        bcd_in = 16'($urandom);
    endtask

    // Counts cycles since the accept edge until out_valid is seen at a negedge (capped).
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        bit ok;
        int cyc;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 14'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b bin_out=%0d err=%b, need 1 0 0 0", in_ready, out_valid, bin_out, err);
        end
        accept(16'h1234, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 14'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_conv: in_ready=%b out_valid=%b bin_out=%0d err=%b, need 1 0 0 0", in_ready, out_valid, bin_out, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept(16'h0042, ok);
        wait_out(cyc);
        checks++;
        if (!ok || cyc != 5 || bin_out !== 14'd42 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover: ok=%b lat=%0d bin_out=%0d err=%b, need 1 5 42 0", ok, cyc, bin_out, err);
        end
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        int cyc;
        accept(16'h1234, ok);
        wait_out(cyc);
        checks++;
        if (!ok || cyc != 5) begin
            errors++;
            $display("FAIL basic_latency: ok=%b lat=%0d, need 1 5", ok, cyc);
        end
        checks++;
        if (bin_out !== 14'd1234 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_value: bin_out=%0d err=%b, need 1234 0", bin_out, err);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bin_out !== 14'd1234) begin
            errors++;
            $display("FAIL basic_idle: out_valid=%b in_ready=%b bin_out=%0d, need 0 1 1234", out_valid, in_ready, bin_out);
        end
    endtask

    task automatic test_extremes;
        logic [15:0] vals [6];
        bit ok;
        int cyc;
        int exp_v;
        bit exp_e;
        vals = '{16'h0000, 16'h9999, 16'h0001, 16'h1000, 16'h12A4, 16'h0005};
        foreach (vals[i]) begin
            exp_v = ref_value(vals[i]);
            exp_e = ref_err(vals[i]);
            accept(vals[i], ok);
            wait_out(cyc);
            checks++;
            if (!ok || cyc != 5 || bin_out !== 14'(exp_v) || err !== exp_e) begin
                errors++;
                $display("FAIL extreme_%h: ok=%b lat=%0d bin_out=%0d err=%b, need lat 5 bin_out %0d err %b",
                         vals[i], ok, cyc, bin_out, err, exp_v, exp_e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int cyc;
        out_ready = 1'b0;
        accept(16'h0777, ok);
        wait_out(cyc);
        in_valid = 1'b1;
        bcd_in = 16'h0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || bin_out !== 14'd777 || in_ready !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: out_valid=%b bin_out=%0d in_ready=%b err=%b, need 1 777 0 0", i, out_valid, bin_out, in_ready, err);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        bcd_in = 16'h9999;
        wait_out(cyc);
        checks++;
        if (cyc != 5 || bin_out !== 14'd1) begin
            errors++;
            $display("FAIL stall_next: lat=%0d bin_out=%0d, need 5 1", cyc, bin_out);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int accepts [$];
        int results [$];
        bit pending;
        pending = 1'b0;
        in_valid = 1'b1;
        bcd_in = 16'h0010;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (pending) begin
                pending = 1'b0;
                if (accepts.size() == 1) bcd_in = 16'h0020;
                else in_valid = 1'b0;
            end
            if (out_valid) results.push_back(int'(bin_out));
            if (in_ready && in_valid) begin
                accepts.push_back(cyc);
                pending = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (accepts.size() != 2 || (accepts.size() == 2 && accepts[1] - accepts[0] != 6)) begin
            errors++;
            $display("FAIL b2b_spacing: accepts=%0d gap=%0d, need 2 accepts 6 apart",
                     accepts.size(), (accepts.size() == 2) ? accepts[1] - accepts[0] : -1);
        end
        checks++;
        if (results.size() != 2 || (results.size() == 2 && (results[0] != 10 || results[1] != 20))) begin
            errors++;
            $display("FAIL b2b_results: count=%0d first=%0d second=%0d, need 2 results 10 20", results.size(),
                     (results.size() > 0) ? results[0] : -1, (results.size() > 1) ? results[1] : -1);
        end
    endtask

    task automatic test_random;
        bit ok;
        int cyc;
        int v;
        logic [15:0] raw;
        for (int i = 0; i < 200; i++) begin
            v = int'($urandom_range(0, 9999));
            accept(split_digits(v), ok);
            wait_out(cyc);
            checks++;
            if (!ok || cyc != 5 || bin_out !== 14'(v) || err !== 1'b0) begin
                errors++;
                $display("FAIL roundtrip_%0d: ok=%b lat=%0d bin_out=%0d err=%b, need %0d err 0", i, ok, cyc, bin_out, err, v);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 50; i++) begin
            raw = 16'($urandom);
            accept(raw, ok);
            wait_out(cyc);
            checks++;
            if (!ok || cyc != 5 || bin_out !== 14'(ref_value(raw)) || err !== ref_err(raw)) begin
                errors++;
                $display("FAIL raw_%h: lat=%0d bin_out=%0d err=%b, need %0d err %b", raw, cyc, bin_out, err, ref_value(raw), ref_err(raw));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        bcd_in = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_basic;
        test_extremes;
        test_backpressure;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
